header_encoder: RTL and testbench
=================================

HEADER_ENCODER -- requirements
Module: header_encoder

Interface
REQ-001 Parameter FRAG_CODE, default 8'hFF: length-byte value sent for a fragment.
REQ-002 Parameter EMPTY_CODE, default 8'h00: length-byte value meaning no payload.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tx_start  input  1  request to send one frame; sampled in IDLE only.
REQ-006 tx_eid  input  8  endpoint ID, captured on accepted tx_start.
REQ-007 tx_len  input  8  payload byte count, captured on accepted tx_start.
REQ-008 tx_is_fragment  input  1  fragment flag, captured on accepted tx_start.
REQ-009 tx_abort  input  1  terminate current frame.
REQ-010 in_data  input  8  payload byte from source.
REQ-011 in_data_valid  input  1  in_data holds a valid byte.
REQ-012 in_data_last  input  1  in_data is the final fragment byte.
REQ-013 in_data_latch  output  1  combinational; source byte consumed this cycle.
REQ-014 out_frame_valid  output  1  frame in progress toward consumer.
REQ-015 out_frame_data  output  8  byte offered to consumer.
REQ-016 out_frame_data_valid  output  1  out_frame_data is valid.
REQ-017 out_frame_data_latch  input  1  consumer pulse: frame-start ack, or byte taken.
REQ-018 tx_busy  output  1  high whenever state is not IDLE.
REQ-019 tx_done  output  1  one-cycle pulse at frame completion or abort.

Function
REQ-020 Transfer rule: a byte moves on any cycle with out_frame_data_valid=1 and out_frame_data_latch=1; a latch pulse with data_valid=0 outside START has no effect.
REQ-021 States: IDLE, START, EID, LEN, PAYLOAD, END.
REQ-022 IDLE: outputs low; tx_start=1 captures tx_eid/tx_len/tx_is_fragment and moves to START on the next edge.
REQ-023 START: out_frame_valid=1, out_frame_data_valid=0; out_frame_data_latch=1 acknowledges the frame start and moves to EID.
REQ-024 EID: out_frame_data=captured eid, data_valid=1; on transfer, move to LEN.
REQ-025 LEN: out_frame_data=FRAG_CODE if fragment, else captured len; data_valid=1; on transfer, move to PAYLOAD, or to END if not fragment and len==EMPTY_CODE.
REQ-026 PAYLOAD: out_frame_data=in_data; out_frame_data_valid=in_data_valid; in_data_latch=in_data_valid & out_frame_data_latch.
REQ-027 Non-fragment: an 8-bit remaining counter loads len in LEN and decrements per transfer; the transfer with remaining==1 moves to END.
REQ-028 Fragment: the transfer carrying in_data_last=1 moves to END; the counter is unused.
REQ-029 A non-fragment with len==FRAG_CODE is forbidden; the caller shall set tx_is_fragment instead.
REQ-030 END: out_frame_valid=0 for exactly one cycle; tx_done=1; return to IDLE, so frames are separated by at least one frame_valid-low cycle.
REQ-031 tx_abort in START..PAYLOAD moves to END on the next edge; in_data_latch=0 that cycle; any partially sent frame is truncated.
REQ-032 tx_abort and a transfer in the same cycle: abort wins; the transfer still counts as taken by the consumer.
REQ-033 tx_start while busy is ignored; captured fields stay stable until IDLE.
REQ-034 Throughput: one byte per cycle when latch is held high; header latency from tx_start to EID offered is 2 cycles plus the start ack.

Reset
REQ-035 rst forces IDLE, counter=0, captured fields=0.
REQ-036 rst holds all outputs at 0 and dominates all other inputs.
REQ-037 rst mid-frame drops out_frame_valid on the following cycle, with no END cycle and no tx_done.

Structure
REQ-038 State encodings, FRAG_CODE, and EMPTY_CODE belong in the shared frame package used by the header decoder.
REQ-039 Single module; no sub-module is required.

Verification
REQ-040 eid=8'h3A, len=3, consumer latch held high: stream shows ack, 3A, 03, three payload bytes, then frame_valid low for 1 cycle and tx_done=1.
REQ-041 len=0, not fragment: bytes EID, 00, then END; in_data_latch never asserts.
REQ-042 Fragment, source asserts last on the 5th byte: length byte is FF, exactly 5 payload bytes, then END.
REQ-043 Consumer latch randomly stalled and in_data_valid gapped: no byte duplicated or dropped, and out_frame_data holds stable while valid is unlatched.
REQ-044 tx_abort during the 2nd payload byte: END next cycle, tx_done=1, tx_busy=0 the cycle after.
REQ-045 rst asserted in LEN: all outputs 0 next cycle; a following tx_start sends a complete, correct frame.

Source files
------------

// File: rtl/header_encoder_pkg.sv
// Shared frame definitions for the header encoder and decoder.
// Holds the FSM state encoding and the reserved length-byte codes.
package header_encoder_pkg;

    localparam logic [7:0] FRAG_CODE_DEF  = 8'hFF;
    localparam logic [7:0] EMPTY_CODE_DEF = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_EID     = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_END     = 3'd5
    } state_t;

endpackage

// File: rtl/header_encoder.sv
// Frame header encoder: emits EID, length byte, then streams the payload.
// Fragments send FRAG_CODE as length and end on the source's last flag.
module header_encoder
    import header_encoder_pkg::*;
#(
    parameter logic [7:0] FRAG_CODE  = FRAG_CODE_DEF,
    parameter logic [7:0] EMPTY_CODE = EMPTY_CODE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_eid,
    input  logic [7:0] tx_len,
    input  logic       tx_is_fragment,
    input  logic       tx_abort,
    input  logic [7:0] in_data,
    input  logic       in_data_valid,
    input  logic       in_data_last,
    output logic       in_data_latch,
    output logic       out_frame_valid,
    output logic [7:0] out_frame_data,
    output logic       out_frame_data_valid,
    input  logic       out_frame_data_latch,
    output logic       tx_busy,
    output logic       tx_done
);

    state_t     state_q, state_d;
    logic [7:0] eid_q, eid_d;
    logic [7:0] len_q, len_d;
    logic       frag_q, frag_d;
    logic [7:0] cnt_q, cnt_d;

    logic       fv_c, dv_c, ilatch_c, busy_c, done_c;
    logic [7:0] data_c;

    // State and captured-field registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            eid_q   <= 8'h00;
            len_q   <= 8'h00;
            frag_q  <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            eid_q   <= eid_d;
            len_q   <= len_d;
            frag_q  <= frag_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Moore/Mealy outputs; abort overrides any progress
    always_comb begin
        state_d  = state_q;
        eid_d    = eid_q;
        len_d    = len_q;
        frag_d   = frag_q;
        cnt_d    = cnt_q;
        fv_c     = 1'b0;
        dv_c     = 1'b0;
        data_c   = 8'h00;
        ilatch_c = 1'b0;
        busy_c   = (state_q != ST_IDLE);
        done_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    eid_d   = tx_eid;
                    len_d   = tx_len;
                    frag_d  = tx_is_fragment;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                fv_c = 1'b1;
                if (tx_abort) begin
                    state_d = ST_END;
                end else if (out_frame_data_latch) begin
                    state_d = ST_EID;
                end
            end
            ST_EID: begin
                fv_c   = 1'b1;
                dv_c   = 1'b1;
                data_c = eid_q;
                if (tx_abort) begin
                    state_d = ST_END;
                end else if (out_frame_data_latch) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                fv_c   = 1'b1;
                dv_c   = 1'b1;
                data_c = frag_q ? FRAG_CODE : len_q;
                if (tx_abort) begin
                    state_d = ST_END;
                end else if (out_frame_data_latch) begin
                    cnt_d = len_q;
                    if (!frag_q && len_q == EMPTY_CODE) begin
                        state_d = ST_END;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                fv_c   = 1'b1;
                dv_c   = in_data_valid;
                data_c = in_data;
                if (tx_abort) begin
                    state_d = ST_END;
                end else begin
                    ilatch_c = in_data_valid & out_frame_data_latch;
                    if (ilatch_c) begin
                        if (frag_q) begin
                            if (in_data_last) begin
                                state_d = ST_END;
                            end
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                            if (cnt_q == 8'd1) begin
                                state_d = ST_END;
                            end
                        end
                    end
                end
            end
            ST_END: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset forces every output low in the same cycle
    assign out_frame_valid      = fv_c & ~rst;
    assign out_frame_data_valid = dv_c & ~rst;
    assign out_frame_data       = rst ? 8'h00 : data_c;
    assign in_data_latch        = ilatch_c & ~rst;
    assign tx_busy              = busy_c & ~rst;
    assign tx_done              = done_c & ~rst;

endmodule

// File: tb/tb_header_encoder.sv
// Self-checking bench for header_encoder.
// Scoreboard of expected consumer bytes, filled at stimulus time.
module tb_header_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_eid;
    logic [7:0] tx_len;
    logic       tx_is_fragment;
    logic       tx_abort;
    logic [7:0] in_data;
    logic       in_data_valid;
    logic       in_data_last;
    logic       in_data_latch;
    logic       out_frame_valid;
    logic [7:0] out_frame_data;
    logic       out_frame_data_valid;
    logic       out_frame_data_latch;
    logic       tx_busy;
    logic       tx_done;

    int n_chk  = 0;
    int n_pass = 0;

    header_encoder dut (
        .clk                  (clk),
        .rst                  (rst),
        .tx_start             (tx_start),
        .tx_eid               (tx_eid),
        .tx_len               (tx_len),
        .tx_is_fragment       (tx_is_fragment),
        .tx_abort             (tx_abort),
        .in_data              (in_data),
        .in_data_valid        (in_data_valid),
        .in_data_last         (in_data_last),
        .in_data_latch        (in_data_latch),
        .out_frame_valid      (out_frame_valid),
        .out_frame_data       (out_frame_data),
        .out_frame_data_valid (out_frame_data_valid),
        .out_frame_data_latch (out_frame_data_latch),
        .tx_busy              (tx_busy),
        .tx_done              (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tx_start             = 1'b0;
        tx_abort             = 1'b0;
        in_data_valid        = 1'b0;
        in_data_last         = 1'b0;
        in_data              = 8'h00;
        out_frame_data_latch = 1'b0;
    endtask

    // One frame: eid/len/fragment, nsrc source bytes, optional random
    // stalls, optional abort when xfer count reaches abort_at (-1: none)
    task automatic run_frame(input logic [7:0] eid, input logic [7:0] len,
                             input bit frag, input int nsrc,
                             input bit rnd, input int abort_at);
        logic [7:0] src_q[$];
        logic [7:0] all_q[$];
        logic [7:0] exp_q[$];
        logic [7:0] prev_data = 8'h00;
        bit   prev_hold = 1'b0;
        bit   done = 1'b0;
        bit   adv;
        int   xfers = 0;
        int   cyc = 0;
        int   taken = 0;
        int   abort_cyc = -10;
        int   done_cyc = -1;
        int   stab_bad = 0;
        int   il_bad = 0;
        int   exp_taken;
        for (int i = 0; i < nsrc; i++) src_q.push_back(8'($urandom));
        all_q.push_back(eid);
        all_q.push_back(frag ? 8'hFF : len);
        foreach (src_q[i]) all_q.push_back(src_q[i]);
        if (abort_at >= 0) begin
            for (int i = 0; i <= abort_at; i++) exp_q.push_back(all_q[i]);
            exp_taken = abort_at - 2;
        end else begin
            exp_q = all_q;
            exp_taken = nsrc;
        end
        tx_eid         = eid;
        tx_len         = len;
        tx_is_fragment = frag;
        tx_start       = 1'b1;
        tick();
        tx_eid         = ~eid;
        tx_len         = ~len;
        tx_is_fragment = ~frag;
        while (!done && cyc < 400) begin
            tx_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data_valid = (src_q.size() > 0) &&
                            (!rnd || $urandom_range(0, 3) != 0);
            in_data = in_data_valid ? src_q[0] : 8'($urandom);
            in_data_last = frag && in_data_valid && src_q.size() == 1;
            out_frame_data_latch = !rnd || $urandom_range(0, 2) != 0;
            tx_abort = (abort_at >= 0 && xfers == abort_at);
            @(negedge clk);
            adv = 1'b0;
            if (prev_hold && out_frame_data_valid &&
                out_frame_data != prev_data) stab_bad++;
            if (out_frame_data_valid && out_frame_data_latch) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(out_frame_data), 32'hFFFF_FFFF);
                end else begin
                    chk("byte", 32'(out_frame_data), 32'(exp_q.pop_front()));
                end
                xfers++;
            end
            if (in_data_latch) begin
                if (!(in_data_valid && out_frame_data_latch &&
                      out_frame_data == in_data)) il_bad++;
                adv = 1'b1;
                taken++;
            end
            if (tx_abort) begin
                abort_cyc = cyc;
                chk("abort_ilatch", 32'(in_data_latch), 0);
            end
            if (tx_done) begin
                done = 1'b1;
                done_cyc = cyc;
                chk("end_fv", 32'(out_frame_valid), 0);
                chk("end_busy", 32'(tx_busy), 1);
            end
            prev_hold = out_frame_data_valid && !out_frame_data_latch;
            prev_data = out_frame_data;
            tick();
            if (adv) void'(src_q.pop_front());
            cyc++;
        end
        tx_start = 1'b0;
        tx_abort = 1'b0;
        chk("done_seen", 32'(done), 1);
        chk("exp_left", 32'(exp_q.size()), 0);
        chk("src_taken", 32'(taken), 32'(exp_taken));
        chk("stable", 32'(stab_bad), 0);
        chk("ilatch_ok", 32'(il_bad), 0);
        if (abort_at >= 0) chk("abort_lat", 32'(done_cyc - abort_cyc), 1);
        chk("idle_busy", 32'(tx_busy), 0);
        chk("idle_fv", 32'(out_frame_valid), 0);
        chk("idle_done", 32'(tx_done), 0);
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tx_eid = 8'h00;
        tx_len = 8'h00;
        tx_is_fragment = 1'b0;
        tick();
        tx_start = 1'b1;
        out_frame_data_latch = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_fv", 32'(out_frame_valid), 0);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_dv", 32'(out_frame_data_valid), 0);
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        chk("idle_busy0", 32'(tx_busy), 0);

        run_frame(8'h3A, 8'd3, 1'b0, 3, 1'b0, -1);
        run_frame(8'h41, 8'd0, 1'b0, 0, 1'b0, -1);
        run_frame(8'h42, 8'd9, 1'b1, 5, 1'b0, -1);
        run_frame(8'h77, 8'd20, 1'b0, 20, 1'b1, -1);
        run_frame(8'h88, 8'd0, 1'b1, 9, 1'b1, -1);
        run_frame(8'h99, 8'd5, 1'b0, 5, 1'b0, 3);
        run_frame(8'h5C, 8'd254, 1'b0, 254, 1'b0, -1);

        tx_eid = 8'h55;
        tx_len = 8'h07;
        tx_is_fragment = 1'b0;
        out_frame_data_latch = 1'b1;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tick();
        @(negedge clk);
        chk("pre_rst_eid", 32'(out_frame_data), 32'h55);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_len_fv", 32'(out_frame_valid), 0);
        chk("rst_len_dv", 32'(out_frame_data_valid), 0);
        chk("rst_len_data", 32'(out_frame_data), 0);
        chk("rst_len_busy", 32'(tx_busy), 0);
        tick();
        rst = 1'b0;
        out_frame_data_latch = 1'b0;
        @(negedge clk);
        chk("post_rst_fv", 32'(out_frame_valid), 0);
        chk("post_rst_done", 32'(tx_done), 0);
        chk("post_rst_busy", 32'(tx_busy), 0);
        tick();
        run_frame(8'h66, 8'd4, 1'b0, 4, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
